// File: rtl/sine_table_encoder_if.sv
// Sample stream and table-write bus between a table source, the encoder and the DDS table memory.
// The slave modport is the encoder's view; master is the source/memory side.
interface sine_table_encoder_if #(
  parameter int unsigned DATA_LEN = 11,
  parameter int unsigned ADDR_W   = 8
);
  logic                s_valid;
  logic                s_ready;
  logic [6:0]          s_data;
  logic                s_last;
  logic [DATA_LEN-1:0] data_wr;
  logic [ADDR_W-1:0]   addr_wr;
  logic                we;

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, data_wr, addr_wr, we
  );

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, data_wr, addr_wr, we
  );
endinterface

// File: rtl/sine_table_encoder.sv
// Run-length encodes a stream of 7-bit quarter-wave samples into packed {amp, hold} table words
// and writes them sequentially into the DDS table memory.
module sine_table_encoder #(
  parameter int unsigned DATA_LEN   = 11,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned MEM_HEIGHT = 256
) (
  input  logic                  src_clk,
  input  logic                  rst,
  input  logic                  start,
  sine_table_encoder_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_W:0]       entries
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StFlush = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  localparam logic [ADDR_W:0] MemTop = (ADDR_W + 1)'(MEM_HEIGHT);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [6:0]          amp_q, amp_d;
  logic [3:0]          run_q, run_d;
  logic                have_q, have_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                emit_req;
  logic                accept;

  assign accept = bus.s_valid && (state_q == StRun);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    amp_d    = amp_q;
    run_d    = run_q;
    have_d   = have_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    emit_req = 1'b0;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          ptr_d   = '0;
          amp_d   = '0;
          run_d   = '0;
          have_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (!have_q) begin
            amp_d  = bus.s_data;
            run_d  = '0;
            have_d = 1'b1;
          end else if ((bus.s_data == amp_q) && (run_q < 4'd15)) begin
            run_d = run_q + 4'd1;
          end else begin
            emit_req = 1'b1;
            amp_d    = bus.s_data;
            run_d    = '0;
          end
          if (bus.s_last) state_d = StFlush;
        end
      end
      StFlush: begin
        // After s_last the run register always holds the final, still-open run.
        emit_req = 1'b1;
        have_d   = 1'b0;
        state_d  = StDone;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // The word emitted is always the run closed by this cycle, i.e. the registered amp/run.
    if (emit_req) begin
      if (ptr_q == MemTop) begin
        ovf_d   = 1'b1;
        state_d = StErr;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end else begin
        we_d         = 1'b1;
        addr_d       = ptr_q[ADDR_W-1:0];
        data_d       = '0;
        data_d[10:0] = {amp_q, run_q};
        ptr_d        = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      amp_q   <= '0;
      run_q   <= '0;
      have_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      amp_q   <= amp_d;
      run_q   <= run_d;
      have_q  <= have_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.s_ready = (state_q == StRun);
  assign bus.we      = we_q;
  assign bus.addr_wr = addr_q;
  assign bus.data_wr = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign entries     = ptr_q;

endmodule

// File: tb/tb_sine_table_encoder.sv
// Drives identical sample streams into a full-size and a 4-word encoder and compares the written
// words against a run-length model of each load.
module tb_sine_table_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       s_valid;
  logic [6:0] s_data;
  logic       s_last;

  logic       busy_b, done_b, ovf_b;
  logic       busy_s, done_s, ovf_s;
  logic [8:0] entries_b, entries_s;

  int n_checks = 0;
  int n_errs   = 0;

  logic [6:0]  stim[$];
  logic [10:0] exp_w[$];
  logic [18:0] wq_b[$];
  logic [18:0] wq_s[$];
  int          done_cnt_b, done_cnt_s;

  always #5 clk = ~clk;

  sine_table_encoder_if #(.DATA_LEN(11), .ADDR_W(8)) bus_b ();
  sine_table_encoder_if #(.DATA_LEN(11), .ADDR_W(8)) bus_s ();

  assign bus_b.s_valid = s_valid;
  assign bus_b.s_data  = s_data;
  assign bus_b.s_last  = s_last;
  assign bus_s.s_valid = s_valid;
  assign bus_s.s_data  = s_data;
  assign bus_s.s_last  = s_last;

  sine_table_encoder #(.DATA_LEN(11), .ADDR_W(8), .MEM_HEIGHT(256)) dut (
    .src_clk  (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus_b),
    .busy     (busy_b),
    .done     (done_b),
    .overflow (ovf_b),
    .entries  (entries_b)
  );

  sine_table_encoder #(.DATA_LEN(11), .ADDR_W(8), .MEM_HEIGHT(4)) dut_small (
    .src_clk  (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus_s),
    .busy     (busy_s),
    .done     (done_s),
    .overflow (ovf_s),
    .entries  (entries_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_b.we) wq_b.push_back({bus_b.addr_wr, bus_b.data_wr});
    if (bus_s.we) begin
      wq_s.push_back({bus_s.addr_wr, bus_s.data_wr});
      check_eq("small_addr_range", 32'(bus_s.addr_wr < 8'd4), 32'd1);
    end
    if (done_b) done_cnt_b++;
    if (done_s) done_cnt_s++;
  end

  // Reference: group consecutive equal samples into runs of at most 16.
  task automatic build_model();
    int i, n;
    exp_w.delete();
    i = 0;
    while (i < stim.size()) begin
      n = 1;
      while ((i + n < stim.size()) && (stim[i+n] == stim[i]) && (n < 16)) n++;
      exp_w.push_back({stim[i], 4'(n - 1)});
      i += n;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    wq_b.delete();
    wq_s.delete();
    done_cnt_b = 0;
    done_cnt_s = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_samples(input int gap_pct);
    for (int i = 0; i < stim.size(); i++) begin
      while ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = stim[i];
      s_last  = (i == stim.size() - 1);
      for (int t = 0; !bus_b.s_ready; t++) begin
        if (t > 20) begin
          check_eq("ready_timeout", 32'(bus_b.s_ready), 32'd1);
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_load(input string tag, input int gap_pct);
    int  t;
    int  h;
    build_model();
    pulse_start();
    send_samples(gap_pct);
    t = 0;
    while (busy_b && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_busy_b"}, 32'(busy_b), 32'd0);
    repeat (2) @(negedge clk);

    check_eq({tag, "_nwords_b"}, wq_b.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < wq_b.size(); k++)
      check_eq($sformatf("%s_word_b%0d", tag, k), 32'(wq_b[k]), 32'({8'(k), exp_w[k]}));
    check_eq({tag, "_entries_b"}, 32'(entries_b), exp_w.size());
    check_eq({tag, "_ovf_b"}, 32'(ovf_b), 32'd0);
    check_eq({tag, "_done_b"}, done_cnt_b, 32'd1);
    check_eq({tag, "_ready_b"}, 32'(bus_b.s_ready), 32'd0);

    h = (exp_w.size() > 4) ? 4 : exp_w.size();
    check_eq({tag, "_nwords_s"}, wq_s.size(), h);
    for (int k = 0; k < h && k < wq_s.size(); k++)
      check_eq($sformatf("%s_word_s%0d", tag, k), 32'(wq_s[k]), 32'({8'(k), exp_w[k]}));
    check_eq({tag, "_entries_s"}, 32'(entries_s), h);
    check_eq({tag, "_ovf_s"}, 32'(ovf_s), 32'(exp_w.size() > 4));
    check_eq({tag, "_done_s"}, done_cnt_s, 32'(exp_w.size() <= 4));
    check_eq({tag, "_busy_s"}, 32'(busy_s), 32'd0);
    check_eq({tag, "_ready_s"}, 32'(bus_s.s_ready), 32'd0);
  endtask

  initial begin
    logic [6:0] v;
    int         len;
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    done_cnt_b = 0;
    done_cnt_s = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_we", 32'(bus_b.we), 32'd0);
    check_eq("rst_busy", 32'(busy_b), 32'd0);
    check_eq("rst_done", 32'(done_b), 32'd0);
    check_eq("rst_ovf", 32'(ovf_b), 32'd0);
    check_eq("rst_entries", 32'(entries_b), 32'd0);
    check_eq("rst_ready", 32'(bus_b.s_ready), 32'd0);
    check_eq("rst_addr", 32'(bus_b.addr_wr), 32'd0);
    check_eq("rst_data", 32'(bus_b.data_wr), 32'd0);

    stim.delete();
    repeat (16) stim.push_back(7'd5);
    run_load("amp5x16", 0);
    check_eq("amp5x16_word", 32'(wq_b.size() > 0 ? wq_b[0] : 19'h7ffff), 32'h0005F);

    stim.push_back(7'd5);
    run_load("amp5x17", 30);

    stim = '{7'd1, 7'd1, 7'd2, 7'd3, 7'd3, 7'd3};
    run_load("runs", 50);

    stim = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
    run_load("overflow", 0);

    // Reset lands while the word for sample 2 is on the write port.
    pulse_start();
    stim = '{7'd1, 7'd2, 7'd3};
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = stim[i];
      @(negedge clk);
    end
    s_valid = 1'b0;
    check_eq("pre_rst_we", 32'(bus_b.we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_we", 32'(bus_b.we), 32'd0);
    check_eq("mid_rst_busy", 32'(busy_b), 32'd0);
    check_eq("mid_rst_entries", 32'(entries_b), 32'd0);
    check_eq("mid_rst_ready", 32'(bus_b.s_ready), 32'd0);
    stim = '{7'd42};
    run_load("after_rst", 0);

    for (int r = 0; r < 8; r++) begin
      stim.delete();
      len = $urandom_range(1, 60);
      v   = 7'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(99) < 25) v = 7'($urandom_range(0, 3));
        stim.push_back(v);
      end
      run_load($sformatf("rand%0d", r), $urandom_range(0, 40));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
